// File: rtl/mont_const_sched.sv
// Scheduler and one-entry result cache in front of the Montgomery constant
// generator. Two requesters share the generator round-robin; a request whose
// modulus matches the cached one is answered without a generator run.
module mont_const_sched #(
  parameter int DATA_LENGTH = 1024,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [DATA_LENGTH-1:0] req0_mod,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DATA_LENGTH-1:0] req1_mod,
  output logic                   req1_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DATA_LENGTH-1:0] rsp_r,
  output logic [DATA_LENGTH-1:0] rsp_t,
  output logic                   rsp_err,
  output logic                   rsp_hit,
  input  logic                   flush,
  output logic                   gen_start,
  output logic [DATA_LENGTH-1:0] gen_mod,
  input  logic [DATA_LENGTH-1:0] gen_r,
  input  logic [DATA_LENGTH-1:0] gen_t,
  input  logic                   gen_done,
  output logic                   busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [TW-1:0]          timer;
  logic                   rr_last;
  logic                   to_settle;
  logic                   id_q;
  logic                   err_q;
  logic                   hit_q;
  logic                   cache_valid;
  logic [DATA_LENGTH-1:0] cache_mod;
  logic [DATA_LENGTH-1:0] cache_r;
  logic [DATA_LENGTH-1:0] cache_t;
  logic [DATA_LENGTH-1:0] mod_q;
  logic [DATA_LENGTH-1:0] r_q;
  logic [DATA_LENGTH-1:0] t_q;

  logic                   grant;
  logic                   sel_id;
  logic [DATA_LENGTH-1:0] sel_mod;
  logic                   mod_zero;
  logic                   mod_hit;
  logic                   wait_done;
  logic                   wait_tout;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  assign sel_id    = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
  assign sel_mod   = sel_id ? req1_mod : req0_mod;
  assign mod_zero  = (sel_mod == '0);
  // A flush in the grant cycle already counts as invalidating the entry.
  assign mod_hit   = cache_valid && !flush && (sel_mod == cache_mod);
  // gen_done is only meaningful while waiting on our own launch.
  assign wait_done = (state == S_WAIT) && gen_done;
  assign wait_tout = (state == S_WAIT) && !gen_done && (timer == T_LAST);

  // Next-state decode plus the grant and start strobes.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gen_start  = 1'b0;
    case (state)
      S_SETTLE: if (gen_done || timer == T_LAST) state_nxt = S_IDLE;
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          req0_ready = ~sel_id;
          req1_ready = sel_id;
          state_nxt  = (mod_zero || mod_hit) ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        gen_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (gen_done || timer == T_LAST) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = to_settle ? S_SETTLE : S_IDLE;
      default:  state_nxt = S_SETTLE;
    endcase
  end

  // Control state: FSM, timer, priority, cache validity and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SETTLE;
      timer       <= '0;
      rr_last     <= 1'b1;
      to_settle   <= 1'b0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      hit_q       <= 1'b0;
      cache_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else if (state == S_SETTLE || state == S_WAIT) timer <= timer + TW'(1);
      if (grant) begin
        id_q      <= sel_id;
        rr_last   <= sel_id;
        err_q     <= mod_zero;
        hit_q     <= !mod_zero && mod_hit;
        to_settle <= 1'b0;
      end
      if (wait_done) begin
        err_q       <= 1'b0;
        hit_q       <= 1'b0;
        cache_valid <= 1'b1;
      end
      if (wait_tout) begin
        err_q       <= 1'b1;
        hit_q       <= 1'b0;
        cache_valid <= 1'b0;
        to_settle   <= 1'b1;
      end
      // Flush wins over a simultaneous fill: the entry ends invalid.
      if (flush) cache_valid <= 1'b0;
    end
  end

  // Wide datapath registers; validity is tracked by the control flops above.
  always_ff @(posedge clk) begin
    if (grant) begin
      mod_q <= sel_mod;
      if (mod_zero) begin
        r_q <= '0;
        t_q <= '0;
      end else if (mod_hit) begin
        r_q <= cache_r;
        t_q <= cache_t;
      end
    end
    if (wait_done) begin
      cache_mod <= mod_q;
      cache_r   <= gen_r;
      cache_t   <= gen_t;
      r_q       <= gen_r;
      t_q       <= gen_t;
    end
    if (wait_tout) begin
      r_q <= '0;
      t_q <= '0;
    end
  end

  // Outputs are gated by state so they read zero right after any reset.
  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_hit   = rsp_valid & hit_q;
  assign rsp_r     = rsp_valid ? r_q : '0;
  assign rsp_t     = rsp_valid ? t_q : '0;
  assign gen_mod   = (state == S_LAUNCH || state == S_WAIT) ? mod_q : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mont_const_sched.sv
// Bench for mont_const_sched: behavioural generator model, cache/arbiter
// reference model and one task per scenario.
module tb_mont_const_sched;

  localparam int DL = 1024;
  localparam int TO = 4096;
  localparam int BOUND = TO + 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic [DL-1:0] req0_mod = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [DL-1:0] req1_mod = '0;
  logic          req1_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [DL-1:0] rsp_r;
  logic [DL-1:0] rsp_t;
  logic          rsp_err;
  logic          rsp_hit;
  logic          flush = 1'b0;
  logic          gen_start;
  logic [DL-1:0] gen_mod;
  logic [DL-1:0] gen_r = '0;
  logic [DL-1:0] gen_t = '0;
  logic          gen_done = 1'b0;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  mont_const_sched #(.DATA_LENGTH(DL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mod(req0_mod), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mod(req1_mod), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_t(rsp_t), .rsp_err(rsp_err), .rsp_hit(rsp_hit),
    .flush(flush), .gen_start(gen_start), .gen_mod(gen_mod),
    .gen_r(gen_r), .gen_t(gen_t), .gen_done(gen_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [DL-1:0] ref_r(input logic [DL-1:0] n);
    logic [DL:0] a;
    a = (n == 1) ? '0 : (DL+1)'(1);
    repeat (DL) begin
      a = a << 1;
      if (a >= {1'b0, n}) a = a - {1'b0, n};
    end
    return a[DL-1:0];
  endfunction

  function automatic logic [DL-1:0] ref_t(input logic [DL-1:0] n);
    logic [DL-1:0] b;
    logic [DL:0]   acc;
    b = ref_r(n);
    acc = '0;
    for (int i = DL - 1; i >= 0; i--) begin
      acc = acc << 1;
      if (acc >= {1'b0, n}) acc = acc - {1'b0, n};
      if (b[i]) begin
        acc = acc + {1'b0, b};
        if (acc >= {1'b0, n}) acc = acc - {1'b0, n};
      end
    end
    return acc[DL-1:0];
  endfunction

  function automatic logic [DL-1:0] rand_mod();
    logic [DL-1:0] v;
    for (int i = 0; i < DL / 32; i++) v[i*32 +: 32] = $urandom;
    v[0] = 1'b1;
    return v;
  endfunction

  // ---------------- cache / arbiter reference model ----------------
  bit            m_valid = 0;
  logic [DL-1:0] m_mod = '0;
  int            m_rr = 1;

  function automatic void model_req(input logic [DL-1:0] n, input int id,
                                    output bit e_err, output bit e_hit);
    e_err = (n == '0);
    e_hit = !e_err && m_valid && (m_mod == n);
    m_rr = id;
    if (!e_err && !e_hit) begin
      m_valid = 1;
      m_mod = n;
    end
  endfunction

  // ---------------- generator model ----------------
  bit            gen_en = 1;
  int            gen_lat = 20;
  bit            gen_busy = 0;
  int            gen_cnt = 0;
  logic [DL-1:0] gen_n = '0;
  logic [DL-1:0] cap_mod = '0;
  int            start_cnt = 0;
  bit            stray_req = 0;
  bit            flush_req = 0;
  bit            flush_on_done = 0;

  always @(negedge clk) begin
    if (gen_start) begin
      start_cnt++;
      cap_mod = gen_mod;
      if (gen_en) begin
        gen_busy = 1;
        gen_cnt = gen_lat;
        gen_n = gen_mod;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    gen_done = stray_req;
    flush = flush_req;
    stray_req = 0;
    flush_req = 0;
    if (gen_busy) begin
      if (gen_cnt == 0) begin
        gen_busy = 0;
        gen_done = 1'b1;
        gen_r = ref_r(gen_n);
        gen_t = ref_t(gen_n);
        if (flush_on_done) begin
          flush = 1'b1;
          flush_on_done = 0;
        end
      end else begin
        gen_cnt--;
      end
    end
  end

  // ---------------- drive / observe helpers (no checking) ----------------
  task automatic wait_grant(input int which, output int cyc, output int g);
    bit got;
    got = 0;
    cyc = 0;
    g = -1;
    while (!got) begin
      @(negedge clk);
      cyc++;
      if ((which != 1 && req0_ready) || (which != 0 && req1_ready)) begin
        g = req1_ready ? 1 : 0;
        got = 1;
      end else if (cyc > BOUND) begin
        cyc = -1;
        got = 1;
      end
    end
  endtask

  task automatic wait_rsp(input bit clr, output int lat, output logic id,
                          output logic err, output logic hit,
                          output logic [DL-1:0] r, output logic [DL-1:0] t);
    bit got;
    @(posedge clk);
    #1;
    if (clr) begin
      req0_valid = 0;
      req1_valid = 0;
    end
    got = 0;
    lat = 0;
    while (!got) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1;
      else if (lat > BOUND) begin
        lat = -1;
        got = 1;
      end
    end
    id = rsp_id; err = rsp_err; hit = rsp_hit; r = rsp_r; t = rsp_t;
  endtask

  int            cyc, g, lat, s0;
  logic          o_id, o_err, o_hit;
  logic [DL-1:0] o_r, o_t, n;
  bit            e_err, e_hit;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    m_valid = 0; m_rr = 1;
    req0_mod = DL'(13);
    req0_valid = 1;
    @(negedge clk);
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req0_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (gen_start !== 1'b0) begin n_bad++; $display("FAIL reset_gen_start: got %b want 0", gen_start); end
    n_cmp++; if (gen_mod !== '0) begin n_bad++; $display("FAIL reset_gen_mod: got %0h want 0", gen_mod); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
  endtask

  task automatic test_first_launch();
    s0 = start_cnt;
    wait_grant(0, cyc, g);
    n_cmp++; if (cyc != TO) begin n_bad++; $display("FAIL settle_grant_cycle: got %0d want %0d", cyc, TO); end
    model_req(DL'(13), 0, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL first_starts: got %0d want 1", start_cnt - s0); end
    n_cmp++; if (cap_mod !== DL'(13)) begin n_bad++; $display("FAIL first_gen_mod: got %0h want d", cap_mod); end
    n_cmp++; if (o_r !== DL'(3)) begin n_bad++; $display("FAIL first_r: got %0h want 3", o_r); end
    n_cmp++; if (o_t !== DL'(9)) begin n_bad++; $display("FAIL first_t: got %0h want 9", o_t); end
    n_cmp++; if ({o_id, o_hit, o_err} !== 3'b000) begin n_bad++; $display("FAIL first_flags: got id/hit/err %b%b%b want 000", o_id, o_hit, o_err); end
  endtask

  task automatic test_hit();
    @(posedge clk); #1;
    req1_mod = DL'(13);
    req1_valid = 1;
    s0 = start_cnt;
    wait_grant(1, cyc, g);
    model_req(DL'(13), 1, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL hit_latency: got %0d want 1", lat); end
    n_cmp++; if (start_cnt != s0) begin n_bad++; $display("FAIL hit_no_start: got %0d want 0", start_cnt - s0); end
    n_cmp++; if (o_hit !== 1'b1 || o_err !== 1'b0) begin n_bad++; $display("FAIL hit_flags: got hit/err %b%b want 10", o_hit, o_err); end
    n_cmp++; if (o_id !== 1'b1) begin n_bad++; $display("FAIL hit_id: got %b want 1", o_id); end
    n_cmp++; if (o_r !== DL'(3) || o_t !== DL'(9)) begin n_bad++; $display("FAIL hit_rt: got %0h/%0h want 3/9", o_r, o_t); end
  endtask

  task automatic test_round_robin();
    int exp_g;
    @(posedge clk); #1;
    req0_mod = DL'(13);
    req1_mod = DL'(11);
    req0_valid = 1;
    req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (m_rr == 1) ? 0 : 1;
      wait_grant(2, cyc, g);
      n_cmp++; if (g != exp_g) begin n_bad++; $display("FAIL rr_grant%0d: got %0d want %0d", k, g, exp_g); end
      n = (g == 1) ? DL'(11) : DL'(13);
      model_req(n, g, e_err, e_hit);
      s0 = start_cnt;
      wait_rsp(0, lat, o_id, o_err, o_hit, o_r, o_t);
      n_cmp++; if (o_id !== 1'(g)) begin n_bad++; $display("FAIL rr_id%0d: got %b want %0d", k, o_id, g); end
      n_cmp++; if (o_hit !== e_hit) begin n_bad++; $display("FAIL rr_hit%0d: got %b want %b", k, o_hit, e_hit); end
      n_cmp++; if (o_r !== ref_r(n) || o_t !== ref_t(n)) begin n_bad++; $display("FAIL rr_rt%0d: got %0h/%0h", k, o_r, o_t); end
      n_cmp++; if (start_cnt - s0 != (e_hit ? 0 : 1)) begin n_bad++; $display("FAIL rr_starts%0d: got %0d want %0d", k, start_cnt - s0, e_hit ? 0 : 1); end
    end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    req0_mod = '0;
    req0_valid = 1;
    s0 = start_cnt;
    wait_grant(0, cyc, g);
    model_req('0, 0, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_err !== 1'b1 || o_hit !== 1'b0) begin n_bad++; $display("FAIL zero_flags: got err/hit %b%b want 10", o_err, o_hit); end
    n_cmp++; if (o_r !== '0 || o_t !== '0) begin n_bad++; $display("FAIL zero_rt: got %0h/%0h want 0/0", o_r, o_t); end
    n_cmp++; if (start_cnt != s0 || lat != 1) begin n_bad++; $display("FAIL zero_nostart: got starts %0d lat %0d want 0 1", start_cnt - s0, lat); end
    // cache entry must survive the error response
    @(posedge clk); #1;
    n = m_mod;
    req1_mod = n;
    req1_valid = 1;
    wait_grant(1, cyc, g);
    model_req(n, 1, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== 1'b1 || o_r !== ref_r(n)) begin n_bad++; $display("FAIL zero_cache_kept: got hit %b r %0h", o_hit, o_r); end
  endtask

  task automatic test_timeout();
    n = rand_mod();
    gen_en = 0;
    @(posedge clk); #1;
    req0_mod = n;
    req0_valid = 1;
    s0 = start_cnt;
    wait_grant(0, cyc, g);
    model_req(n, 0, e_err, e_hit);
    m_valid = 0;
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (lat != TO + 2) begin n_bad++; $display("FAIL tout_latency: got %0d want %0d", lat, TO + 2); end
    n_cmp++; if (o_err !== 1'b1 || o_hit !== 1'b0) begin n_bad++; $display("FAIL tout_flags: got err/hit %b%b want 10", o_err, o_hit); end
    n_cmp++; if (o_r !== '0 || o_t !== '0) begin n_bad++; $display("FAIL tout_rt: got %0h/%0h want 0/0", o_r, o_t); end
    n_cmp++; if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL tout_starts: got %0d want 1", start_cnt - s0); end
    gen_en = 1;
    @(posedge clk); #1;
    req0_valid = 1;
    s0 = start_cnt;
    wait_grant(0, cyc, g);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL tout_regrant: got timeout want grant"); end
    model_req(n, 0, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== 1'b0 || start_cnt - s0 != 1) begin n_bad++; $display("FAIL tout_miss_after: got hit %b starts %0d want 0 1", o_hit, start_cnt - s0); end
    n_cmp++; if (o_r !== ref_r(n) || o_t !== ref_t(n)) begin n_bad++; $display("FAIL tout_rerun_rt: got %0h/%0h", o_r, o_t); end
  endtask

  task automatic test_reset_mid();
    int bad;
    n = rand_mod();
    gen_en = 0;
    @(posedge clk); #1;
    req0_mod = n;
    req0_valid = 1;
    wait_grant(0, cyc, g);
    @(posedge clk); #1;
    req0_valid = 0;
    for (int i = 0; i < 5 && !gen_start; i++) @(negedge clk);
    repeat (101) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_valid = 0; m_rr = 1;
    req1_mod = DL'(13);
    req1_valid = 1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || gen_mod !== '0) begin n_bad++; $display("FAIL midrst_outputs: got rsp_valid %b gen_mod %0h want 0 0", rsp_valid, gen_mod); end
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (req1_ready || rsp_valid || gen_start) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL midrst_settle_quiet: got %0d active cycles want 0", bad); end
    stray_req = 1;
    gen_en = 1;
    s0 = start_cnt;
    wait_grant(1, cyc, g);
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL midrst_grant_after_done: got %0d want 2", cyc); end
    model_req(DL'(13), 1, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== 1'b0 || start_cnt - s0 != 1) begin n_bad++; $display("FAIL midrst_cache_cleared: got hit %b starts %0d want 0 1", o_hit, start_cnt - s0); end
    n_cmp++; if (o_r !== DL'(3) || o_t !== DL'(9) || o_id !== 1'b1) begin n_bad++; $display("FAIL midrst_rsp: got %0h/%0h id %b", o_r, o_t, o_id); end
  endtask

  task automatic test_flush_rsp_held();
    @(posedge clk); #1;
    rsp_ready = 0;
    req0_mod = DL'(13);
    req0_valid = 1;
    wait_grant(0, cyc, g);
    model_req(DL'(13), 0, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== e_hit) begin n_bad++; $display("FAIL flush_pre_hit: got %b want %b", o_hit, e_hit); end
    flush_req = 1;
    stray_req = 1;
    m_valid = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_hit !== 1'b1) begin n_bad++; $display("FAIL flush_held_ctl: got v/id/hit %b%b%b want 101", rsp_valid, rsp_id, rsp_hit); end
    n_cmp++; if (rsp_r !== DL'(3) || rsp_t !== DL'(9)) begin n_bad++; $display("FAIL flush_held_rt: got %0h/%0h want 3/9", rsp_r, rsp_t); end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1;
    s0 = start_cnt;
    wait_grant(0, cyc, g);
    model_req(DL'(13), 0, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== 1'b0 || start_cnt - s0 != 1) begin n_bad++; $display("FAIL flush_miss_after: got hit %b starts %0d want 0 1", o_hit, start_cnt - s0); end
  endtask

  task automatic test_flush_with_done();
    n = rand_mod();
    flush_on_done = 1;
    @(posedge clk); #1;
    req1_mod = n;
    req1_valid = 1;
    s0 = start_cnt;
    wait_grant(1, cyc, g);
    model_req(n, 1, e_err, e_hit);
    m_valid = 0;
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_r !== ref_r(n) || o_t !== ref_t(n) || o_hit !== 1'b0) begin n_bad++; $display("FAIL fdone_rsp: got %0h/%0h hit %b", o_r, o_t, o_hit); end
    @(posedge clk); #1;
    req1_valid = 1;
    s0 = start_cnt;
    wait_grant(1, cyc, g);
    model_req(n, 1, e_err, e_hit);
    wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
    n_cmp++; if (o_hit !== 1'b0 || start_cnt - s0 != 1) begin n_bad++; $display("FAIL fdone_invalid: got hit %b starts %0d want 0 1", o_hit, start_cnt - s0); end
  endtask

  task automatic test_random_mix();
    logic [DL-1:0] pool [3];
    int id;
    pool[0] = DL'(13);
    pool[1] = DL'(11);
    pool[2] = rand_mod();
    for (int k = 0; k < 8; k++) begin
      id = int'($urandom_range(1, 0));
      n = pool[$urandom_range(2, 0)];
      @(posedge clk); #1;
      if (id == 1) begin req1_mod = n; req1_valid = 1; end
      else begin req0_mod = n; req0_valid = 1; end
      s0 = start_cnt;
      wait_grant(id, cyc, g);
      model_req(n, id, e_err, e_hit);
      wait_rsp(1, lat, o_id, o_err, o_hit, o_r, o_t);
      n_cmp++;
      if (o_id !== 1'(id) || o_hit !== e_hit || o_r !== ref_r(n) || o_t !== ref_t(n) ||
          start_cnt - s0 != (e_hit ? 0 : 1)) begin
        n_bad++;
        $display("FAIL rand%0d: got id %b hit %b starts %0d want id %0d hit %b", k, o_id, o_hit, start_cnt - s0, id, e_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_launch();
    test_hit();
    test_round_robin();
    test_zero();
    test_timeout();
    test_reset_mid();
    test_flush_rsp_held();
    test_flush_with_done();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
